// File: rtl/xrbus_frame_rx.sv
// xrbus_frame_rx: deserializes a 68-beat XR-BUS transfer, unpacks fields, checks hash/framing/reserved bits
module xrbus_frame_rx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      module_id,
    output logic [15:0]      boundary_id,
    output logic [7:0]       op_code,
    output logic [63:0]      device_time,
    output logic [63:0]      fabric_time,
    output logic [63:0]      cloud_time,
    output logic [127:0]     trace_id,
    output logic [127:0]     parent_id,
    output logic [31:0]      semantic_hash,
    output logic [1023:0]    payload,
    output logic [9:0]       payload_len,
    output logic [31:0]      version,
    output logic             hash_ok,
    output logic             len_err,
    output logic             rsv_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);
    typedef enum logic [1:0] {RECV, DRAIN, CHECK, OUT} state_t;
    state_t state_q, state_d;
    logic [6:0] bcnt_q, bcnt_d;
    logic [1585:0] frm_q, frm_d;
    logic [255:0] hsh_q, hsh_d, exp_hash;
    logic len_q, len_d, rsv_q, rsv_d, ok_q, ok_d;
    logic [CNT_W-1:0] fok_q, fok_d, fbad_q, fbad_d;
    assign in_ready      = (state_q == RECV) || (state_q == DRAIN);
    assign out_valid     = (state_q == OUT);
    assign module_id     = frm_q[15:0];
    assign boundary_id   = frm_q[31:16];
    assign op_code       = frm_q[39:32];
    assign device_time   = frm_q[103:40];
    assign fabric_time   = frm_q[167:104];
    assign cloud_time    = frm_q[231:168];
    assign trace_id      = frm_q[359:232];
    assign parent_id     = frm_q[487:360];
    assign semantic_hash = frm_q[519:488];
    assign payload       = frm_q[1543:520];
    assign payload_len   = frm_q[1553:1544];
    assign version       = frm_q[1585:1554];
    assign hash_ok       = ok_q;
    assign len_err       = len_q;
    assign rsv_err       = rsv_q;
    assign frames_ok     = fok_q;
    assign frames_bad    = fbad_q;
    assign exp_hash = {216'b0, module_id, boundary_id, op_code}
                    ^ {192'b0, device_time[31:0], fabric_time[31:0]}
                    ^ {128'b0, trace_id[63:0], parent_id[63:0]};
    // Next-state, beat capture, reserved-bit accumulation and saturating counters
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        frm_d   = frm_q;
        hsh_d   = hsh_q;
        len_d   = len_q;
        rsv_d   = rsv_q;
        ok_d    = ok_q;
        fok_d   = fok_q;
        fbad_d  = fbad_q;
        case (state_q)
            RECV: if (in_valid) begin
                if (bcnt_q == 7'd0) begin
                    frm_d = '0;
                    hsh_d = '0;
                    len_d = 1'b0;
                    rsv_d = 1'b0;
                    ok_d  = 1'b0;
                end
                for (int k = 0; k < 24; k++)
                    if (bcnt_q == 7'(k)) frm_d[k*64 +: 64] = in_data;
                if (bcnt_q == 7'd24) frm_d[1585:1536] = in_data[49:0];
                for (int k = 0; k < 4; k++)
                    if (bcnt_q == 7'(64 + k)) hsh_d[k*64 +: 64] = in_data;
                rsv_d = rsv_d | ((bcnt_q == 7'd24) ? |in_data[63:50] :
                                 (bcnt_q > 7'd24 && bcnt_q < 7'd64) ? |in_data : 1'b0);
                bcnt_d = bcnt_q + 7'd1;
                if (in_last) begin
                    len_d   = (bcnt_q != 7'd67);
                    state_d = CHECK;
                end else if (bcnt_q == 7'd67) begin
                    len_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = (in_valid && in_last) ? CHECK : DRAIN;
            CHECK: begin
                ok_d    = !len_q && (hsh_q == exp_hash);
                state_d = OUT;
            end
            OUT: if (out_ready) begin
                state_d = RECV;
                bcnt_d  = 7'd0;
                fok_d   = ok_q ? fok_q + {{(CNT_W-1){1'b0}}, ~&fok_q} : fok_q;
                fbad_d  = ok_q ? fbad_q : fbad_q + {{(CNT_W-1){1'b0}}, ~&fbad_q};
            end
            default: state_d = RECV;
        endcase
    end
    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RECV;
            bcnt_q  <= '0;
            frm_q   <= '0;
            hsh_q   <= '0;
            len_q   <= 1'b0;
            rsv_q   <= 1'b0;
            ok_q    <= 1'b0;
            fok_q   <= '0;
            fbad_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            frm_q   <= frm_d;
            hsh_q   <= hsh_d;
            len_q   <= len_d;
            rsv_q   <= rsv_d;
            ok_q    <= ok_d;
            fok_q   <= fok_d;
            fbad_q  <= fbad_d;
        end
    end
endmodule

// File: tb/tb_xrbus_frame_rx.sv
// tb_xrbus_frame_rx: directed checks of decode, hash, framing, reserved bits, stall, saturation and reset
module tb_xrbus_frame_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, hash_ok, len_err, rsv_err, out_valid;
  logic [15:0] module_id, boundary_id;
  logic [7:0] op_code;
  logic [63:0] device_time, fabric_time, cloud_time;
  logic [127:0] trace_id, parent_id;
  logic [31:0] semantic_hash, version;
  logic [1023:0] payload;
  logic [9:0] payload_len;
  logic [1:0] frames_ok, frames_bad;
  int n_vec = 0, n_err = 0;
  logic [4095:0] gf, rf;
  logic [255:0] gh, bh;
  xrbus_frame_rx #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .module_id(module_id), .boundary_id(boundary_id), .op_code(op_code),
    .device_time(device_time), .fabric_time(fabric_time), .cloud_time(cloud_time),
    .trace_id(trace_id), .parent_id(parent_id), .semantic_hash(semantic_hash),
    .payload(payload), .payload_len(payload_len), .version(version), .hash_ok(hash_ok),
    .len_err(len_err), .rsv_err(rsv_err), .out_valid(out_valid), .out_ready(out_ready),
    .frames_ok(frames_ok), .frames_bad(frames_bad)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [1023:0] o, input logic [1023:0] e);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic send(input int nb, input int last_at, input logic [4095:0] f,
                      input logic [255:0] h, input bit fin);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      chk("in_ready_beat", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = (b < 64) ? f[b*64 +: 64] : (b < 68) ? h[(b-64)*64 +: 64] : 64'hBAD0_0000_0000_0000 | 64'(b);
      in_last  = (b == last_at);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (fin) begin
      chk("lat_check_valid", out_valid, 1'b0);
      chk("lat_check_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1'b1);
    end
  endtask
  task automatic check_frame(input int nb, input logic [4095:0] f, input logic eok,
                             input logic elen, input logic ersv);
    logic [4095:0] e;
    e = (nb >= 64) ? f : f & ((4096'(1) << (nb * 64)) - 4096'(1));
    chk("module_id", module_id, e[15:0]);
    chk("boundary_id", boundary_id, e[31:16]);
    chk("op_code", op_code, e[39:32]);
    chk("device_time", device_time, e[103:40]);
    chk("fabric_time", fabric_time, e[167:104]);
    chk("cloud_time", cloud_time, e[231:168]);
    chk("trace_id", trace_id, e[359:232]);
    chk("parent_id", parent_id, e[487:360]);
    chk("semantic_hash", semantic_hash, e[519:488]);
    chk("payload_eq", payload === e[1543:520], 1'b1);
    chk("payload_len", payload_len, e[1553:1544]);
    chk("version", version, e[1585:1554]);
    chk("hash_ok", hash_ok, eok);
    chk("len_err", len_err, elen);
    chk("rsv_err", rsv_err, ersv);
  endtask
  task automatic consume(input logic [1:0] eok, input logic [1:0] ebad);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_ready", in_ready, 1'b1);
    chk("frames_ok", frames_ok, eok);
    chk("frames_bad", frames_bad, ebad);
  endtask
  initial begin
    gf = '0;
    gf[15:0]      = 16'h1234;
    gf[31:16]     = 16'hABCD;
    gf[39:32]     = 8'h5A;
    gf[103:40]    = 64'd1;
    gf[167:104]   = 64'd2;
    gf[231:168]   = 64'h0123_4567_89AB_CDEF;
    gf[519:488]   = 32'h600D_F00D;
    gf[1543:520]  = {32{32'hDEAD_BEEF}};
    gf[1553:1544] = 10'h3FF;
    gf[1585:1554] = 32'hC0FF_EE01;
    gh = 256'h0000_0013_34AB_CD58;
    bh = 256'h0000_0013_34AB_CD59;
    rf = gf;
    rf[2000] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_module_id", module_id, 16'h0);
    chk("rst_hash_ok", hash_ok, 1'b0);
    chk("rst_frames_ok", frames_ok, 2'd0);
    chk("rst_frames_bad", frames_bad, 2'd0);
    send(68, 67, gf, gh, 1'b1);
    check_frame(68, gf, 1'b1, 1'b0, 1'b0);
    consume(2'd1, 2'd0);
    send(68, 67, gf, bh, 1'b1);
    check_frame(68, gf, 1'b0, 1'b0, 1'b0);
    consume(2'd1, 2'd1);
    send(31, 30, gf, gh, 1'b1);
    check_frame(31, gf, 1'b0, 1'b1, 1'b0);
    consume(2'd1, 2'd2);
    send(3, 2, gf, gh, 1'b1);
    check_frame(3, gf, 1'b0, 1'b1, 1'b0);
    chk("early_payload_zero", payload, 1024'h0);
    consume(2'd1, 2'd3);
    send(68, 67, gf, gh, 1'b1);
    check_frame(68, gf, 1'b1, 1'b0, 1'b0);
    consume(2'd2, 2'd3);
    send(71, 70, gf, gh, 1'b1);
    check_frame(68, gf, 1'b0, 1'b1, 1'b0);
    consume(2'd2, 2'd3);
    send(68, 67, rf, gh, 1'b1);
    check_frame(68, gf, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = '1;
      in_last  = 1'b1;
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_module_id", module_id, 16'h1234);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_frame(68, gf, 1'b1, 1'b0, 1'b1);
    consume(2'd3, 2'd3);
    send(68, 67, gf, gh, 1'b1);
    consume(2'd3, 2'd3);
    send(40, -1, gf, gh, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_frame(0, gf, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_frames_ok", frames_ok, 2'd0);
    chk("mid_rst_frames_bad", frames_bad, 2'd0);
    send(68, 67, gf, gh, 1'b1);
    check_frame(68, gf, 1'b1, 1'b0, 1'b0);
    consume(2'd1, 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xrbus_frame_rx.md
Name: xrbus_frame_rx

Overview:
- Receive side of the XR-BUS frame link. Accepts a serialized XR-BUS frame as 64-bit beats over a valid/ready stream, deserializes it, and unpacks every header field and the payload.
- Recomputes the frame integrity hash, compares it against the transmitted hash trailer, and checks framing and the reserved region.
- Presents the decoded frame plus status flags on an output valid/ready handshake. Sits between the XR-BUS link deserializer and the consuming XR module.

Parameters:
- CNT_W, 16, width of the saturating good/bad frame counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_data  in  64  beat data; beat k carries frame bits [64k+63:64k]
- in_valid  in  1  beat valid
- in_last  in  1  marks final beat of a transfer
- in_ready  out  1  beat accepted when in_valid && in_ready
- module_id  out  16  frame[15:0]
- boundary_id  out  16  frame[31:16]
- op_code  out  8  frame[39:32]
- device_time  out  64  frame[103:40]
- fabric_time  out  64  frame[167:104]
- cloud_time  out  64  frame[231:168]
- trace_id  out  128  frame[359:232]
- parent_id  out  128  frame[487:360]
- semantic_hash  out  32  frame[519:488]
- payload  out  1024  frame[1543:520]
- payload_len  out  10  frame[1553:1544]
- version  out  32  frame[1585:1554]
- hash_ok  out  1  recomputed hash equals received hash
- len_err  out  1  framing error (in_last misplaced or missing)
- rsv_err  out  1  nonzero bit in frame[4095:1586]
- out_valid  out  1  decoded frame available
- out_ready  in  1  consumer accepts the frame
- frames_ok  out  CNT_W  saturating count of frames delivered with hash_ok=1, len_err=0
- frames_bad  out  CNT_W  saturating count of all other frames delivered

Behaviour:
- Transfer format: 68 beats. Beats 0..63 carry the 4096-bit frame. Beats 64..67 carry the 256-bit hash, LSB beat first. in_last is asserted on beat 67 only.
- Expected hash: H = zext256({module_id,boundary_id,op_code}) ^ zext256({device_time[31:0],fabric_time[31:0]}) ^ zext256({trace_id[63:0],parent_id[63:0]}). H[255:128] is therefore always 0.
- hash_ok = (received hash == H) over all 256 bits.
- rsv_err: OR of frame bits [4095:1586]. It is a status flag only; the frame is not dropped.
- FSM states:
  - RECV: in_ready=1; 7-bit beat counter bcnt increments on each accepted beat.
  - DRAIN: in_ready=1; beats are discarded until a beat with in_last is accepted, then go to CHECK.
  - CHECK: in_ready=0; one cycle; compute hash_ok and register the status flags.
  - OUT: in_ready=0; out_valid=1; all outputs held stable until out_ready.
- Transitions:
  - RECV, bcnt 0..66, in_last=0: stay in RECV.
  - RECV, in_last on bcnt<67: early end. Set len_err, go to CHECK. Fields not yet received keep the value 0 from the start-of-frame clear.
  - RECV, bcnt==67 with in_last: go to CHECK.
  - RECV, bcnt==67 without in_last: set len_err, go to DRAIN.
  - DRAIN, in_last accepted: go to CHECK.
  - CHECK: go to OUT.
  - OUT, out_ready: go to RECV, bcnt=0.
- Start-of-frame clear: when bcnt==0 and a beat is accepted, the field registers, hash register, len_err and rsv_err are cleared before that beat is captured.
- If len_err=1, hash_ok is forced to 0.
- Latency: out_valid rises 2 cycles after the cycle in which the final beat is accepted.
- Counters update in the cycle of the out_valid && out_ready handshake. Each counter saturates at all-ones and does not wrap.
- No back-to-back overlap: in_ready=0 from CHECK until the output handshake completes.
- Reset (any state, including mid-frame):
  - FSM goes to RECV, bcnt=0, in_ready=1.
  - out_valid=0.
  - All field outputs, hash_ok, len_err, rsv_err, frames_ok, frames_bad cleared to 0.
  - A partially received frame is discarded.

Test Plan:
- Good frame: module_id=0x1234, boundary_id=0xABCD, op_code=0x5A, device_time=1, fabric_time=2, trace/parent=0, payload_len=0x3FF; hash beat64=0x0000001334ABCD58, beats 65..67=0 -> out_valid 2 cycles after beat 67; fields match; hash_ok=1, len_err=0, rsv_err=0; frames_ok=1.
- Same frame, beat64=0x0000001334ABCD59 -> hash_ok=0; frames_bad=1, frames_ok unchanged.
- Frame with in_last on beat 30 -> len_err=1, hash_ok=0, payload bits beyond frame bit 1983 read as 0; next 68-beat frame decodes correctly.
- in_last missing on beat 67, asserted on beat 70 -> beats 68..70 discarded; out_valid after beat 70; len_err=1.
- Good frame with frame bit 2000 set -> rsv_err=1, hash_ok=1; counted in frames_ok.
- out_ready held 0 for 10 cycles -> outputs stable and in_ready=0 throughout. rst asserted at bcnt=40 of the following frame -> all outputs 0, and a fresh frame then decodes correctly.
